// File: rtl/sram_pkg.sv
// Shared types, constants and helpers for the 1RW/1R synchronous SRAM model.
// Holds the sequencer state encoding and the byte-lane write merge.
package sram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Widest word the merge helper handles; callers cast in and out.
   localparam int MERGE_W = 256;

   // Take bit i from new_word when its lane (i / gran) is enabled in mask.
   function automatic logic [MERGE_W-1:0] lane_merge(
      input logic [MERGE_W-1:0] old_word,
      input logic [MERGE_W-1:0] new_word,
      input logic [MERGE_W-1:0] mask,
      input int                 gran
   );
      logic [MERGE_W-1:0] res;
      res = old_word;
      for (int i = 0; i < MERGE_W; i++) begin
         if (mask[i / gran]) res[i] = new_word[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read output stage: one or two registers, cleared by reset.
// Each stage loads only when fed, so an idle port holds its last word.
module sram_rd_pipe
   import sram_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] q1;

   // First stage captures the array word on every accepted read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1 <= '0;
      end else if (en) begin
         q1 <= din;
      end
   end

   if (RD_LATENCY == RD_LAT_MAX) begin : g_lat2
      logic                  v1;
      logic [DATA_WIDTH-1:0] q2;

      // Second stage follows the first one cycle later, only for real reads.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v1 <= 1'b0;
            q2 <= '0;
         end else begin
            v1 <= en;
            if (v1) q2 <= q1;
         end
      end

      assign dout = q2;
   end else begin : g_lat1
      assign dout = q1;
   end

endmodule

// File: rtl/sram_1rw1r_sync.sv
// Parametrised 1RW + 1R synchronous SRAM with masked writes,
// selectable read latency, collision policy and a zeroing sweep.
module sram_1rw1r_sync
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 9,
   parameter int WMASK_GRAN    = 8,
   parameter int RD_LATENCY    = 1,
   parameter int COLLISION_FWD = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             csb0,
   input  logic                             web0,
   input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]            addr0,
   input  logic [DATA_WIDTH-1:0]            din0,
   output logic [DATA_WIDTH-1:0]            dout0,
   input  logic                             csb1,
   input  logic [ADDR_WIDTH-1:0]            addr1,
   output logic [DATA_WIDTH-1:0]            dout1,
   output logic                             init_busy,
   output logic                             collision
);

   localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;

   if (WMASK_GRAN < 1) begin : g_err_gran0
      $error("WMASK_GRAN must be positive");
   end else if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_err_gran
      $error("DATA_WIDTH must be a multiple of WMASK_GRAN");
   end
   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_err_lat
      $error("RD_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH > MERGE_W || NUM_WMASKS < 1) begin : g_err_width
      $error("DATA_WIDTH out of supported range");
   end

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  ready;
   logic                  we0;
   logic                  re0;
   logic                  re1;
   logic                  hit;
   logic [DATA_WIDTH-1:0] old0;
   logic [DATA_WIDTH-1:0] old1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] rdata1;

   assign ready  = (state == READY);
   assign we0    = ready & ~csb0 & ~web0 & (|wmask0);
   assign re0    = ready & ~csb0 & web0;
   assign re1    = ready & ~csb1;
   assign hit    = we0 & re1 & (addr0 == addr1);
   assign old0   = mem[addr0];
   assign old1   = mem[addr1];
   assign wdata0 = DATA_WIDTH'(lane_merge(MERGE_W'(old0),
                                          MERGE_W'(din0),
                                          MERGE_W'(wmask0),
                                          WMASK_GRAN));
   assign rdata1 = (hit && COLLISION_FWD != 0) ? wdata0 : old1;

   assign init_busy = ~ready;

   // Sequencer: sweep every address once after reset, then serve ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= (INIT_ON_RESET != 0) ? INIT : READY;
         cnt       <= '0;
         collision <= 1'b0;
      end else begin
         collision <= hit;
         if (state == INIT) begin
            if (&cnt) begin
               state <= READY;
            end else begin
               cnt <= cnt + ADDR_WIDTH'(1);
            end
         end
      end
   end

   // Array write: zero words during the sweep, masked port 0 writes after.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else if (we0) begin
            mem[addr0] <= wdata0;
         end
      end
   end

   sram_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pipe0 (
      .clk  (clk),
      .rst  (rst),
      .en   (re0),
      .din  (old0),
      .dout (dout0)
   );

   sram_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pipe1 (
      .clk  (clk),
      .rst  (rst),
      .en   (re1),
      .din  (rdata1),
      .dout (dout1)
   );

endmodule

// File: tb/tb_sram_1rw1r_sync.sv
// Bench for sram_1rw1r_sync: two instances (latency 1 / forward new data,
// latency 2 / keep old data) share stimulus and a word-level memory model.
module tb_sram_1rw1r_sync;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [3:0]  addr0;
   logic [31:0] din0;
   logic        csb1;
   logic [3:0]  addr1;

   logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
   logic        a_busy, a_coll, b_busy, b_coll;

   int total  = 0;
   int passed = 0;

   // Reference state
   logic [31:0] m [DEPTH];
   int          init_left;
   logic [31:0] e0a, e1a, e0b, e1b, p0d, p1d;
   bit          p0v, p1v;
   logic        ecoll;

   sram_1rw1r_sync #(
      .DATA_WIDTH (32), .ADDR_WIDTH (4), .WMASK_GRAN (8),
      .RD_LATENCY (1), .COLLISION_FWD (1), .INIT_ON_RESET (1)
   ) dut_a (
      .clk (clk), .rst (rst),
      .csb0 (csb0), .web0 (web0), .wmask0 (wmask0),
      .addr0 (addr0), .din0 (din0), .dout0 (a_dout0),
      .csb1 (csb1), .addr1 (addr1), .dout1 (a_dout1),
      .init_busy (a_busy), .collision (a_coll)
   );

   sram_1rw1r_sync #(
      .DATA_WIDTH (32), .ADDR_WIDTH (4), .WMASK_GRAN (8),
      .RD_LATENCY (2), .COLLISION_FWD (0), .INIT_ON_RESET (1)
   ) dut_b (
      .clk (clk), .rst (rst),
      .csb0 (csb0), .web0 (web0), .wmask0 (wmask0),
      .addr0 (addr0), .din0 (din0), .dout0 (b_dout0),
      .csb1 (csb1), .addr1 (addr1), .dout1 (b_dout1),
      .init_busy (b_busy), .collision (b_coll)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0]  k);
      logic [31:0] r;
      r = o;
      for (int l = 0; l < 4; l++) begin
         if (k[l]) r[8*l +: 8] = n[8*l +: 8];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      e0a = '0; e1a = '0; e0b = '0; e1b = '0;
      p0d = '0; p1d = '0; p0v = 0; p1v = 0;
      ecoll = 0;
      init_left = DEPTH;
   endtask

   task automatic idle();
      csb0 = 1; web0 = 1; wmask0 = '0; addr0 = '0; din0 = '0;
      csb1 = 1; addr1 = '0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] k);
      csb0 = 0; web0 = 0; wmask0 = k; addr0 = a; din0 = d;
   endtask

   // Advance one clock: predict from current inputs, then compare.
   task automatic cyc();
      bit          rd0, wrq, rd1;
      logic [31:0] mrg;
      if (rst) begin
         ecoll = 0;
      end else if (init_left > 0) begin
         m[DEPTH - init_left] = '0;
         init_left--;
         ecoll = 0;
         p0v = 0; p1v = 0;
      end else begin
         rd0 = !csb0 && web0;
         wrq = !csb0 && !web0 && (wmask0 != 0);
         rd1 = !csb1;
         if (p0v) e0b = p0d;
         if (p1v) e1b = p1d;
         p0v = rd0;
         p1v = rd1;
         mrg = merge(m[addr0], din0, wmask0);
         ecoll = wrq && rd1 && (addr0 == addr1);
         if (rd0) begin
            e0a = m[addr0];
            p0d = m[addr0];
         end
         if (rd1) begin
            e1a = ecoll ? mrg : m[addr1];
            p1d = m[addr1];
         end
         if (wrq) m[addr0] = mrg;
      end
      @(posedge clk);
      #1;
      chk("a_dout0", a_dout0, e0a);
      chk("a_dout1", a_dout1, e1a);
      chk("b_dout0", b_dout0, e0b);
      chk("b_dout1", b_dout1, e1b);
      chk("a_coll", 32'(a_coll), 32'(ecoll));
      chk("b_coll", 32'(b_coll), 32'(ecoll));
      chk("a_busy", 32'(a_busy), 32'(init_left > 0));
      chk("b_busy", 32'(b_busy), 32'(init_left > 0));
   endtask

   initial begin
      int n;
      idle();
      rst = 1;
      model_reset();
      #1;
      chk("rst_a_dout0", a_dout0, 32'h0);
      chk("rst_a_dout1", a_dout1, 32'h0);
      chk("rst_b_dout1", b_dout1, 32'h0);
      chk("rst_a_coll", 32'(a_coll), 32'h0);
      chk("rst_a_busy", 32'(a_busy), 32'h1);
      cyc();
      cyc();
      rst = 0;

      n = 0;
      while (a_busy && n < 40) begin
         cyc();
         n++;
      end
      chk("init_len", 32'(n), 32'd16);

      for (int a = 0; a < DEPTH; a++) begin
         csb0 = 0; web0 = 1; addr0 = 4'(a);
         csb1 = 0; addr1 = 4'(DEPTH - 1 - a);
         cyc();
      end
      idle();
      cyc();
      cyc();

      wr(4'd5, 32'hAABBCCDD, 4'b1111);
      cyc();
      wr(4'd5, 32'h11223344, 4'b0101);
      cyc();
      idle();
      csb0 = 0; web0 = 1; addr0 = 4'd5;
      csb1 = 0; addr1 = 4'd5;
      cyc();
      chk("rmw_a_dout0", a_dout0, 32'hAA22CC44);
      chk("rmw_a_dout1", a_dout1, 32'hAA22CC44);
      idle();
      cyc();
      chk("rmw_b_dout0", b_dout0, 32'hAA22CC44);
      chk("rmw_b_dout1", b_dout1, 32'hAA22CC44);

      wr(4'd7, 32'h01234567, 4'b1111);
      cyc();
      wr(4'd7, 32'hDEADBEEF, 4'b0011);
      csb1 = 0; addr1 = 4'd7;
      cyc();
      chk("col_a_dout1", a_dout1, 32'h0123BEEF);
      chk("col_a_flag", 32'(a_coll), 32'h1);
      chk("col_b_flag", 32'(b_coll), 32'h1);
      idle();
      cyc();
      chk("col_b_dout1", b_dout1, 32'h01234567);
      chk("col_a_drop", 32'(a_coll), 32'h0);

      wr(4'd1, 32'h10, 4'b1111);
      cyc();
      wr(4'd2, 32'h20, 4'b1111);
      cyc();
      wr(4'd3, 32'h30, 4'b1111);
      cyc();
      idle();
      csb1 = 0; addr1 = 4'd1;
      cyc();
      addr1 = 4'd2;
      cyc();
      chk("lat2_first", b_dout1, 32'h10);
      addr1 = 4'd3;
      cyc();
      chk("lat2_second", b_dout1, 32'h20);
      csb1 = 1;
      cyc();
      chk("lat2_third", b_dout1, 32'h30);
      cyc();
      chk("lat2_hold", b_dout1, 32'h30);

      wr(4'd3, 32'h55, 4'b1111);
      cyc();
      wr(4'd3, 32'hFFFFFFFF, 4'b0000);
      csb1 = 0; addr1 = 4'd3;
      cyc();
      chk("m0_a_dout1", a_dout1, 32'h55);
      chk("m0_a_coll", 32'(a_coll), 32'h0);
      idle();
      csb0 = 0; web0 = 1; addr0 = 4'd3;
      cyc();
      chk("m0_b_dout1", b_dout1, 32'h55);
      chk("m0_a_dout0", a_dout0, 32'h55);

      repeat (400) begin
         csb0   = 1'($urandom_range(0, 1));
         web0   = 1'($urandom_range(0, 1));
         wmask0 = 4'($urandom_range(0, 15));
         addr0  = 4'($urandom_range(0, 15));
         din0   = $urandom;
         csb1   = 1'($urandom_range(0, 1));
         addr1  = ($urandom_range(0, 1) == 1) ? addr0
                                               : 4'($urandom_range(0, 15));
         cyc();
      end

      idle();
      rst = 1;
      model_reset();
      cyc();
      rst = 0;
      repeat (8) cyc();
      rst = 1;
      model_reset();
      repeat (3) cyc();
      rst = 0;
      n = 0;
      while (a_busy && n < 40) begin
         csb0 = 0; web0 = (n % 2) == 1; wmask0 = 4'hF;
         addr0 = 4'(n); din0 = $urandom;
         csb1 = 0; addr1 = 4'(n);
         cyc();
         n++;
      end
      chk("reinit_len", 32'(n), 32'd16);
      chk("reinit_dout0", a_dout0, 32'h0);
      idle();
      for (int a = 0; a < DEPTH; a++) begin
         csb0 = 0; web0 = 1; addr0 = 4'(a);
         csb1 = 0; addr1 = 4'(a);
         cyc();
      end
      idle();
      cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
